bayer_frame_bank_scheduler: RTL and testbench

- Sequences capture of the 12-bit Bayer pixel stream into a two-bank external frame RAM.
- Generates linear write addresses and tracks per-bank full/empty state.
- Hands completed banks to the downstream interpolation engine with a request/grant/done handshake.
- Sits between the sensor pixel deserializer (dozen_in/pixeldata_flag) and the frame RAM / interpolation read side.

---
 rtl/bayer_frame_bank_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_bayer_frame_bank_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_frame_bank_scheduler.sv
// Two-bank Bayer frame capture scheduler: linear write addressing, per-bank full tracking, read grant arbitration.
// Latency: accepted pixel reaches the frame RAM port one cycle later; read grant follows rd_req by one cycle.
// Backpressure: none on the pixel stream; pixels arriving with no free bank are dropped and flagged in overflow_err.
module bayer_frame_bank_scheduler #(
    parameter int IMG_COLS = 2592,
    parameter int IMG_ROWS = 1944,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 23
) (
    input  logic              sysClk,
    input  logic              rst_n,
    input  logic              start_capture,
    input  logic              abort_capture,
    input  logic [PIX_W-1:0]  dozen_in,
    input  logic              pixeldata_flag,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              frame_ready,
    input  logic              rd_req,
    output logic              rd_grant,
    output logic              rd_bank,
    input  logic              rd_done,
    output logic              busy,
    output logic              overflow_err
);

    localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_WAIT_BANK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    logic [1:0] bank_full, bank_full_nxt;
    logic       oldest, oldest_nxt;
    logic       grant_nxt, rd_bank_nxt;

    logic free0, free1, any_free, pick;
    logic at_last;
    logic enter_cap, accept, frame_end, drop_err;

    // A granted bank is always full, but both terms are kept so the writer
    // can never land on a bank the consumer owns.
    assign free0    = ~bank_full[0] & ~(rd_grant & ~rd_bank);
    assign free1    = ~bank_full[1] & ~(rd_grant &  rd_bank);
    assign any_free = free0 | free1;
    assign pick     = ~free0;
    assign at_last  = (row == LAST_ROW) && (col == LAST_COL);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        enter_cap = 1'b0;
        accept    = 1'b0;
        frame_end = 1'b0;
        drop_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_capture) begin
                    if (any_free) begin
                        state_nxt = ST_CAPTURE;
                        enter_cap = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT_BANK;
                    end
                end
            end
            ST_WAIT_BANK: begin
                drop_err = pixeldata_flag;
                if (abort_capture) begin
                    state_nxt = ST_IDLE;
                end else if (any_free) begin
                    state_nxt = ST_CAPTURE;
                    enter_cap = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Abort wins over a last pixel in the same cycle, so a
                // partially written bank is never marked full.
                if (abort_capture) begin
                    state_nxt = ST_IDLE;
                end else if (pixeldata_flag) begin
                    accept = 1'b1;
                    if (at_last) begin
                        frame_end = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bank_full_nxt = bank_full;
        oldest_nxt    = oldest;
        grant_nxt     = rd_grant;
        rd_bank_nxt   = rd_bank;
        if (frame_end) begin
            bank_full_nxt[wr_bank] = 1'b1;
            if (!bank_full[~wr_bank]) begin
                oldest_nxt = wr_bank;
            end
        end
        if (!rd_grant) begin
            if (rd_req && (|bank_full)) begin
                grant_nxt   = 1'b1;
                rd_bank_nxt = bank_full[oldest] ? oldest : ~bank_full[0];
            end
        end else if (rd_done) begin
            grant_nxt              = 1'b0;
            bank_full_nxt[rd_bank] = 1'b0;
            oldest_nxt             = ~rd_bank;
        end
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_bank      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            frame_ready  <= 1'b0;
            rd_grant     <= 1'b0;
            rd_bank      <= 1'b0;
            overflow_err <= 1'b0;
            bank_full    <= 2'b00;
            oldest       <= 1'b0;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
        end else begin
            wr_en      <= accept;
            frame_done <= frame_end;
            if (accept) begin
                wr_data <= dozen_in;
                wr_addr <= addr;
            end
            if (enter_cap) begin
                col     <= '0;
                row     <= '0;
                addr    <= '0;
                wr_bank <= pick;
            end else if (accept) begin
                addr <= addr + ADDR_W'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            overflow_err <= overflow_err | drop_err;
            bank_full    <= bank_full_nxt;
            oldest       <= oldest_nxt;
            rd_grant     <= grant_nxt;
            rd_bank      <= rd_bank_nxt;
            frame_ready  <= (|bank_full_nxt) & ~grant_nxt;
        end
    end

endmodule

// File: tb/tb_bayer_frame_bank_scheduler.sv
// Bench for bayer_frame_bank_scheduler on a 4x3 frame: vector table, directed corner sequences, random traffic vs a queue model.
module tb_bayer_frame_bank_scheduler;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int PW    = 12;
    localparam int AW    = 23;
    localparam int FRAME = COLS * ROWS;

    logic          sysClk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_capture = 1'b0;
    logic          abort_capture = 1'b0;
    logic [PW-1:0] dozen_in = '0;
    logic          pixeldata_flag = 1'b0;
    logic          rd_req = 1'b0;
    logic          rd_done = 1'b0;
    logic          wr_en, wr_bank, frame_done, frame_ready, rd_grant, rd_bank, busy, overflow_err;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;

    always #5 sysClk = ~sysClk;

    bayer_frame_bank_scheduler #(
        .IMG_COLS(COLS), .IMG_ROWS(ROWS), .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .sysClk(sysClk), .rst_n(rst_n), .start_capture(start_capture), .abort_capture(abort_capture),
        .dozen_in(dozen_in), .pixeldata_flag(pixeldata_flag), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .frame_ready(frame_ready),
        .rd_req(rd_req), .rd_grant(rd_grant), .rd_bank(rd_bank), .rd_done(rd_done),
        .busy(busy), .overflow_err(overflow_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: writer mode, pixel count in frame, and full banks kept in completion order.
    int   m_st;
    int   m_cnt;
    bit   m_wb, m_gb, m_gr, m_ovf, m_en, m_fd;
    int   m_addr, m_data;
    int   fullq[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_full(input int b);
        foreach (fullq[i]) if (fullq[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_wb = 0; m_gb = 0; m_gr = 0; m_ovf = 0;
        m_en = 0; m_fd = 0; m_addr = 0; m_data = 0;
        fullq.delete();
    endtask

    task automatic model_step(input bit s, input bit f, input logic [PW-1:0] d,
                              input bit rq, input bit dn, input bit ab);
        bit f0, f1, comp;
        f0 = !is_full(0);
        f1 = !is_full(1);
        comp = 1'b0;
        m_en = 1'b0;
        m_fd = 1'b0;
        case (m_st)
            0: if (s) begin
                if (f0 || f1) begin m_st = 1; m_wb = !f0; m_cnt = 0; end
                else m_st = 2;
            end
            2: begin
                if (f) m_ovf = 1'b1;
                if (ab) m_st = 0;
                else if (f0 || f1) begin m_st = 1; m_wb = !f0; m_cnt = 0; end
            end
            default: begin
                if (ab) m_st = 0;
                else if (f) begin
                    m_en = 1'b1; m_addr = m_cnt; m_data = int'(d);
                    m_cnt++;
                    if (m_cnt == FRAME) begin m_fd = 1'b1; comp = 1'b1; m_st = 0; end
                end
            end
        endcase
        if (!m_gr) begin
            if (rq && fullq.size() > 0) begin m_gr = 1'b1; m_gb = (fullq[0] == 1); end
        end else if (dn) begin
            m_gr = 1'b0;
            fullq.delete(0);
        end
        if (comp) fullq.push_back(m_wb ? 1 : 0);
    endtask

    task automatic compare_all();
        chk1("wr_en", wr_en, m_en);
        chk1("frame_done", frame_done, m_fd);
        chk1("frame_ready", frame_ready, (fullq.size() > 0) && !m_gr);
        chk1("rd_grant", rd_grant, m_gr);
        chk1("rd_bank", rd_bank, m_gb);
        chk1("busy", busy, m_st != 0);
        chk1("overflow_err", overflow_err, m_ovf);
        chk1("wr_bank", wr_bank, m_wb);
        if (m_en) begin
            chkv("wr_addr", 32'(wr_addr), m_addr);
            chkv("wr_data", 32'(wr_data), m_data);
        end
    endtask

    task automatic cyc(input bit s, input bit f, input logic [PW-1:0] d,
                       input bit rq, input bit dn, input bit ab);
        start_capture = s; pixeldata_flag = f; dozen_in = d;
        rd_req = rq; rd_done = dn; abort_capture = ab;
        @(posedge sysClk);
        model_step(s, f, d, rq, dn, ab);
        #1;
        compare_all();
    endtask

    task automatic px(input logic [PW-1:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chkv({tag, "_outs"}, {20'd0, wr_en, wr_bank, frame_done, frame_ready, rd_grant, rd_bank,
                              busy, overflow_err, 4'd0}, 32'd0);
        chkv({tag, "_addr"}, 32'(wr_addr), 32'd0);
        chkv({tag, "_data"}, 32'(wr_data), 32'd0);
    endtask

    typedef struct {
        bit            s, f;
        logic [PW-1:0] d;
        bit            en, fd, rdy, bsy;
        int            addr;
        logic [PW-1:0] data;
    } vec_t;

    vec_t tbl[FRAME+2];

    initial begin
        int nexp;
        for (int k = 0; k < FRAME + 2; k++) begin
            tbl[k] = '{default: 0};
            if (k == 0) begin
                tbl[k].s = 1'b1; tbl[k].bsy = 1'b1;
            end else if (k <= FRAME) begin
                tbl[k].f = 1'b1; tbl[k].d = 12'(k);
                tbl[k].en = 1'b1; tbl[k].addr = k - 1; tbl[k].data = 12'(k);
                tbl[k].fd = (k == FRAME); tbl[k].rdy = (k == FRAME); tbl[k].bsy = (k != FRAME);
            end else begin
                tbl[k].rdy = 1'b1;
            end
        end

        model_reset();
        repeat (2) @(posedge sysClk);
        #1;
        chk_zero("reset");
        compare_all();
        rst_n = 1'b1;

        // First frame from the vector table into bank 0.
        for (int k = 0; k < FRAME + 2; k++) begin
            cyc(tbl[k].s, tbl[k].f, tbl[k].d, 1'b0, 1'b0, 1'b0);
            chk1("tbl_wr_en", wr_en, tbl[k].en);
            chk1("tbl_frame_done", frame_done, tbl[k].fd);
            chk1("tbl_frame_ready", frame_ready, tbl[k].rdy);
            chk1("tbl_busy", busy, tbl[k].bsy);
            chk1("tbl_wr_bank", wr_bank, 1'b0);
            if (tbl[k].en) begin
                chkv("tbl_wr_addr", 32'(wr_addr), tbl[k].addr);
                chkv("tbl_wr_data", 32'(wr_data), 32'(tbl[k].data));
            end
        end

        // Gapped flags fill bank 1 with contiguous addresses.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        nexp = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, (i % 2) == 0, 12'h100 + 12'(i / 2), 1'b0, 1'b0, 1'b0);
            if (wr_en) begin
                chkv("gap_addr", 32'(wr_addr), nexp);
                chk1("gap_bank", wr_bank, 1'b1);
                nexp++;
            end
        end
        chkv("gap_pulses", nexp, FRAME);

        // Both banks full: third start waits, pixels overflow, bank 0 is read first.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("wait_busy", busy, 1'b1);
        repeat (3) begin
            px(12'hABC);
            chk1("wait_no_wr", wr_en, 1'b0);
        end
        chk1("wait_overflow", overflow_err, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk1("wait_grant", rd_grant, 1'b1);
        chk1("wait_grant_bank", rd_bank, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk1("wait_release", rd_grant, 1'b0);
        idle();
        chk1("resume_bank", wr_bank, 1'b0);
        px(12'h2AA);
        chk1("resume_wr", wr_en, 1'b1);
        chkv("resume_addr", 32'(wr_addr), 32'd0);

        // Abort after 5 pixels, then restart into the same bank.
        for (int i = 1; i < 5; i++) px(12'(i));
        cyc(1'b0, 1'b1, 12'h555, 1'b0, 1'b0, 1'b1);
        chk1("abort_no_wr", wr_en, 1'b0);
        chk1("abort_no_done", frame_done, 1'b0);
        chk1("abort_idle", busy, 1'b0);
        chk1("abort_ready", frame_ready, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("restart_bank", wr_bank, 1'b0);
        px(12'h3C0);
        chkv("restart_addr", 32'(wr_addr), 32'd0);
        for (int i = 1; i < FRAME; i++) px(12'h3C0 + 12'(i));
        chk1("restart_done", frame_done, 1'b1);

        // Bank 1 completed first, so it is granted first; then bank 0 is held while bank 1 refills.
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk1("order_bank1", rd_bank, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk1("order_bank0", rd_bank, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("refill_bank", wr_bank, 1'b1);
        for (int i = 0; i < FRAME - 1; i++) px(12'h7F0 + 12'(i));
        cyc(1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0);
        chk1("coinc_done", frame_done, 1'b1);
        chk1("coinc_grant", rd_grant, 1'b0);
        chk1("coinc_ready", frame_ready, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk1("coinc_next_bank", rd_bank, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a frame.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("pre_rst_bank", wr_bank, 1'b0);
        for (int i = 0; i < 7; i++) px(12'h0A0 + 12'(i));
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge sysClk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("post_rst_bank", wr_bank, 1'b0);
        px(12'h123);
        chkv("post_rst_addr", 32'(wr_addr), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60, 12'($urandom),
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
